// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter family:
// FSM state enum, requester indices and the circular priority pick.
package arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    localparam logic [1:0] REQ_A = 2'd0;
    localparam logic [1:0] REQ_B = 2'd1;
    localparam logic [1:0] REQ_C = 2'd2;
    localparam logic [1:0] REQ_D = 2'd3;

    // Returns {found, idx}: first set bit of req searching upward from last+1, wrapping.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic [2:0] res;
        res = 3'b000;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!res[2] && req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester/consumer bundle of the shared 4:1 mux: request lines and data in,
// grant, select, enable, muxed data and busy out.
interface rr_mux_arbiter_if #(
    parameter int DATA_W = 1
);
    logic [3:0]        req;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] d;
    logic [3:0]        gnt;
    logic [1:0]        se;
    logic              en;
    logic [DATA_W-1:0] y;
    logic              busy;

    modport master (
        output req, a, b, c, d,
        input  gnt, se, en, y, busy
    );

    modport slave (
        input  req, a, b, c, d,
        output gnt, se, en, y, busy
    );
endinterface

// File: rtl/rr_pick4.sv
// Combinational circular priority encoder over four request lines,
// starting the search just after the last owner.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [3:0] i_req,
    input  logic [1:0] i_last,
    output logic       o_found,
    output logic [1:0] o_idx
);

    logic [2:0] w_pick;

    assign w_pick  = rr_pick(i_req, i_last);
    assign o_found = w_pick[2];
    assign o_idx   = w_pick[1:0];

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a shared 4:1 data mux with registered grant/select/enable.
// Optional per-owner grant limit enabled by defining ARB_HOLD_LIMIT_EN (limit = MAX_HOLD cycles).
module rr_mux_arbiter
    import arb_pkg::*;
#(
    parameter int DATA_W   = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_mux_arbiter_if.slave   bus
);

    arb_state_t        r_state;
    logic [3:0]        r_gnt;
    logic [1:0]        r_se;
    logic              r_en;
    logic [1:0]        r_last;

    logic [3:0]        w_pick_req;
    logic [1:0]        w_pick_last;
    logic              w_found;
    logic [1:0]        w_idx;
    logic [3:0]        w_others;
    logic              w_force;
    logic              w_rotate;
    logic [DATA_W-1:0] w_y;

    // While granted, the owner is masked out so a forced rotation cannot re-pick it.
    assign w_others    = bus.req & ~r_gnt;
    assign w_pick_req  = (r_state == ST_IDLE) ? bus.req : w_others;
    assign w_pick_last = (r_state == ST_IDLE) ? r_last : r_se;

    rr_pick4 u_pick (
        .i_req   (w_pick_req),
        .i_last  (w_pick_last),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

`ifdef ARB_HOLD_LIMIT_EN
    localparam int HC_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_TOP = HC_W'(MAX_HOLD - 1);

    logic [HC_W-1:0] r_hold;

    assign w_force = (r_hold == HOLD_TOP) && (|w_others);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (r_state == ST_IDLE || w_rotate) begin
            r_hold <= '0;
        end else if (r_hold != HOLD_TOP) begin
            r_hold <= r_hold + 1'b1;
        end
    end
`else
    assign w_force = 1'b0;
`endif

    assign w_rotate = !bus.req[r_se] || w_force;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= 4'b0000;
            r_se    <= 2'b00;
            r_en    <= 1'b0;
            r_last  <= REQ_D;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state <= ST_GRANT;
                        r_gnt   <= onehot4(w_idx);
                        r_se    <= w_idx;
                        r_en    <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (w_rotate) begin
                        r_last <= r_se;
                        if (w_found) begin
                            r_gnt <= onehot4(w_idx);
                            r_se  <= w_idx;
                        end else begin
                            r_state <= ST_IDLE;
                            r_gnt   <= 4'b0000;
                            r_se    <= 2'b00;
                            r_en    <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 4'b0000;
                    r_se    <= 2'b00;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_y = '0;
        if (r_en) begin
            case (r_se)
                REQ_A:   w_y = bus.a;
                REQ_B:   w_y = bus.b;
                REQ_C:   w_y = bus.c;
                REQ_D:   w_y = bus.d;
                default: w_y = '0;
            endcase
        end
    end

    assign bus.gnt  = r_gnt;
    assign bus.se   = r_se;
    assign bus.en   = r_en;
    assign bus.busy = r_en;
    assign bus.y    = w_y;

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4:1 data multiplexer between four requesters.
- Converts per-requester request lines into registered one-hot grants plus the mux select and enable.
- Drives the muxed data output.
- Sits in front of any shared single-consumer resource, e.g. a shared bus or output port, fed by four sources.

Parameters:
- DATA_W, 1, width of each data input and of y.
- MAX_HOLD, 8, maximum consecutive grant cycles per requester when ARB_HOLD_LIMIT_EN is defined; legal range 2..256.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- req  input  4  request lines; bit i belongs to requester i (0=a, 1=b, 2=c, 3=d).
- a  input  DATA_W  requester 0 data.
- b  input  DATA_W  requester 1 data.
- c  input  DATA_W  requester 2 data.
- d  input  DATA_W  requester 3 data.
- gnt  output  4  registered one-hot grant; all zeros when idle.
- se  output  2  registered mux select; equals the index of the set gnt bit.
- en  output  1  registered mux enable; high exactly when gnt is nonzero.
- y  output  DATA_W  combinational: selected input when en=1, else all zeros (never X or Z).
- busy  output  1  equals en; provided for status and debug.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State=IDLE, gnt=0, se=2'b00, en=0, busy=0.
  - Round-robin pointer last=3, so requester 0 has first priority.
  - hold_cnt=0.
  - Reset overrides everything, including mid-grant; grant drops on the next edge.
- States: IDLE, GRANT.
- Winner selection: first set req bit, searching circularly from (last+1) mod 4 upward.
- IDLE:
  - If req!=0, register the winner. Next cycle: gnt=onehot(win), se=win, en=1, state=GRANT.
  - Latency from req to gnt is exactly 1 cycle.
- GRANT, granted bit g = se:
  - req[g]=1 and no forced rotation: hold grant; hold_cnt increments and saturates at MAX_HOLD-1.
  - req[g]=0 (release): set last=g and re-arbitrate the remaining requests in the same cycle.
    - Another request pending: next cycle grants the new winner directly; zero idle cycles between owners.
    - None pending: next cycle gnt=0, en=0, state=IDLE.
  - hold_cnt is cleared on every change of owner.
- Simultaneous requests: only the rotation pointer decides. Requester g loses priority to all others right after it releases.
- Glitch-free switching: gnt, se and en change only on clock edges. gnt is always one-hot or zero.
- Request lines not currently granted may toggle freely; they are only sampled at arbitration points.

Optional Feature:
- Macro: ARB_HOLD_LIMIT_EN.
- Defined:
  - If hold_cnt==MAX_HOLD-1 and any other req bit is set, rotation is forced even though req[g]=1.
  - Forced rotation behaves exactly like a release: last=g, the next winner is granted next cycle, hold_cnt=0.
  - If no other requester is pending, the grant stays with g and hold_cnt stays saturated.
- Undefined:
  - Grant is held as long as req[g]=1, with no upper bound.
  - hold_cnt logic is absent; no counter flops are synthesised.

Decomposition:
- Shared package arb_pkg holds:
  - The state enum (ST_IDLE, ST_GRANT).
  - Requester index constants (REQ_A..REQ_D = 0..3).
  - A function rr_pick(req, last) returning {found, idx}.
- One natural sub-module: rr_pick4, the combinational circular priority encoder.
  - Inputs: req[3:0], last[1:0]. Outputs: found, idx[1:0].
  - Reusable by future arbiters.
- The 4:1 data select stays inline in rr_mux_arbiter.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles with req=4'b1111 → gnt=0, en=0, y=0 throughout. Release reset → gnt=4'b0001 and se=0 one cycle later.
- Single requester: req=4'b0100 held 5 cycles, then dropped, with c=1 (DATA_W=1) → gnt=4'b0100 and y=1 for 5 cycles. gnt returns to 0 one cycle after req[2] falls.
- Rotation: req=4'b1111 with each owner dropping its req for 1 cycle after 2 granted cycles → grant order 0,1,2,3,0, with no idle cycle between owners.
- Fairness after release: last=1, req=4'b0011 → next grant goes to 0. Then with last=0, req=4'b0011 → grant goes to 1.
- Hold limit (ARB_HOLD_LIMIT_EN, MAX_HOLD=4): req[0] held constantly and req[3] asserted → gnt moves to 4'b1000 after exactly 4 cycles of gnt[0]. With req[3]=0, gnt[0] is held for 20 cycles.
- Reset mid-grant: rst_n=0 for one cycle while gnt=4'b0010 → next cycle gnt=0 and en=0. After reset, req=4'b0011 → grant goes to 0, confirming last was reset to 3.
